// File: rtl/bf_cfg_pkg.sv
// bf_cfg_pkg: shared constants, FSM states and weight-set type for the beamformer weight config block.
package bf_cfg_pkg;
  localparam int N_LANE = 8;
  localparam int W_BITS = 5;
  localparam int SET_COS1 = 0;
  localparam int SET_SIN1 = 1;
  localparam int SET_COS2 = 2;
  localparam int SET_SIN2 = 3;
  localparam logic [6:0] ADDR_ABORT = 7'h0E;
  localparam logic [6:0] ADDR_COMMIT = 7'h0F;
  localparam bit AUTO_COMMIT = 1'b1;
  typedef enum logic [1:0] {IDLE, COLLECT, ARMED} state_t;
  typedef logic [N_LANE-1:0][W_BITS-1:0] weight_set_t;
endpackage

// File: rtl/bf_cfg_decode.sv
// bf_cfg_decode: splits a 32-bit command frame into write, command and error indications.
module bf_cfg_decode
  import bf_cfg_pkg::*;
(
  input  logic                   valid_i,
  input  logic [31:0]            data_i,
  output logic                   is_write_o,
  output logic [1:0]             set_o,
  output logic                   half_o,
  output logic [3:0][W_BITS-1:0] wts_o,
  output logic                   is_commit_o,
  output logic                   is_abort_o,
  output logic                   is_err_o
);
  logic       wr;
  logic [6:0] addr;
  logic [2:0] idx;
  logic       unused_ign;
  assign wr = valid_i & data_i[31];
  assign addr = data_i[30:24];
  assign idx = addr[2:0] - 3'd1;
  assign is_write_o = wr && addr >= 7'd1 && addr <= 7'd8;
  assign set_o = idx[2:1];
  assign half_o = idx[0];
  assign wts_o = data_i[19:0];
  assign is_commit_o = wr && addr == ADDR_COMMIT;
  assign is_abort_o = wr && addr == ADDR_ABORT;
  assign is_err_o = wr && !is_write_o && !is_commit_o && !is_abort_o;
  assign unused_ign = ^data_i[23:20];
endmodule

// File: rtl/bf_weight_cfg_ctrl.sv
// bf_weight_cfg_ctrl: shadow/active weight banks with tick-aligned atomic commit,
// abort, status and saturating bad-frame counter.
module bf_weight_cfg_ctrl
  import bf_cfg_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_valid,
  input  logic [31:0]              frame_data,
  input  logic                     ds_tick,
  output logic [N_LANE*W_BITS-1:0] w_cos_1,
  output logic [N_LANE*W_BITS-1:0] w_sin_1,
  output logic [N_LANE*W_BITS-1:0] w_cos_2,
  output logic [N_LANE*W_BITS-1:0] w_sin_2,
  output logic                     cfg_pending,
  output logic                     cfg_valid,
  output logic                     commit_pulse,
  output logic [7:0]               written_mask,
  output logic [7:0]               err_cnt
);
  logic                   dec_write, dec_half, dec_commit, dec_abort, dec_err;
  logic [1:0]             dec_set;
  logic [3:0][W_BITS-1:0] dec_wts;
  weight_set_t [3:0]      shadow_q, shadow_d, act_q, act_d;
  logic [7:0]             mask_q, mask_d, err_q, err_d;
  logic                   valid_q, valid_d, pulse_q, pulse_d, commit, abort;
  state_t                 state_q, state_d;

  bf_cfg_decode u_decode (
    .valid_i     (frame_valid),
    .data_i      (frame_data),
    .is_write_o  (dec_write),
    .set_o       (dec_set),
    .half_o      (dec_half),
    .wts_o       (dec_wts),
    .is_commit_o (dec_commit),
    .is_abort_o  (dec_abort),
    .is_err_o    (dec_err)
  );

  // Abort beats a same-cycle tick; a same-cycle write commits the pre-write shadow.
  assign abort = dec_abort && state_q != IDLE;
  assign commit = state_q == ARMED && ds_tick && !abort;

  always_comb begin
    shadow_d = shadow_q;
    act_d = act_q;
    mask_d = mask_q;
    state_d = state_q;
    err_d = err_q;
    valid_d = valid_q;
    pulse_d = commit;
    if (commit) begin
      act_d = shadow_q;
      mask_d = '0;
      state_d = IDLE;
      valid_d = 1'b1;
    end
    if (abort) begin
      shadow_d = act_q;
      mask_d = '0;
      state_d = IDLE;
    end
    if (dec_write) begin
      for (int j = 0; j < 4; j++) shadow_d[dec_set][{dec_half, 2'(j)}] = dec_wts[j];
      mask_d[{dec_set, dec_half}] = 1'b1;
      state_d = (AUTO_COMMIT && mask_d == 8'hFF) || (state_q == ARMED && !commit) ? ARMED : COLLECT;
    end
    if (dec_commit && state_q == COLLECT) state_d = ARMED;
    if (dec_err || (dec_commit && state_q == IDLE)) err_d = err_q + {7'd0, err_q != 8'hFF};
  end

  always_ff @(posedge clock)
    if (!reset) begin
      shadow_q <= '0;
      act_q <= '0;
      mask_q <= '0;
      err_q <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      shadow_q <= shadow_d;
      act_q <= act_d;
      mask_q <= mask_d;
      err_q <= err_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
    end

  assign w_cos_1 = act_q[SET_COS1];
  assign w_sin_1 = act_q[SET_SIN1];
  assign w_cos_2 = act_q[SET_COS2];
  assign w_sin_2 = act_q[SET_SIN2];
  assign cfg_pending = state_q == ARMED;
  assign cfg_valid = valid_q;
  assign commit_pulse = pulse_q;
  assign written_mask = mask_q;
  assign err_cnt = err_q;
endmodule
